// File: rtl/multi_net_replay_buffer.sv
// Captures one gamma window of first-spike times from N networks into ping-pong banks
// and replays each network's window serially into one shared column with a net tag.
module multi_net_replay_buffer #(
    parameter int P     = 64,
    parameter int N     = 2,
    parameter int GAMMA = 16,
    parameter int TW    = $clog2(GAMMA),
    parameter int NW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                grst,
    input  logic [N-1:0][P-1:0] data_in,
    output logic                in_ready,
    output logic                overrun,
    output logic [P-1:0]        data_out,
    output logic                col_grst,
    output logic [NW-1:0]       net_id,
    output logic                replay_active
);
    typedef enum logic {C_IDLE, C_CAPT} cap_state_t;
    typedef enum logic {R_IDLE, R_PLAY} rep_state_t;

    localparam logic [TW-1:0] LAST_T   = TW'(GAMMA - 1);
    localparam logic [NW-1:0] LAST_NET = NW'(N - 1);

    cap_state_t          c_state;
    logic [TW-1:0]       cap_cnt;
    logic                wr;
    rep_state_t          r_state;
    logic [NW-1:0]       net_cnt;
    logic [TW-1:0]       t;
    logic                rd;
    logic [1:0]          full;

    logic [N-1:0][P-1:0] valid_q [2];
    logic [TW-1:0]       off_q   [2][N][P];

    logic                cap_start;
    logic                cap_capt;
    logic                cap_done;
    logic [N-1:0][P-1:0] off_we;

    logic                r_go;
    logic                r_free;
    logic [NW-1:0]       nxt_net;
    logic [TW-1:0]       nxt_t;
    logic [P-1:0]        nxt_data;

    // Handshake: grst is the valid and in_ready the ready; a window starts only on an
    // edge where both are high. A grst seen with in_ready low is dropped and sets overrun.
    assign in_ready  = (c_state == C_IDLE) && !full[wr];
    assign cap_start = grst && in_ready;
    assign cap_capt  = (c_state == C_CAPT);
    assign cap_done  = cap_capt && (cap_cnt == LAST_T);

    always_comb begin
        off_we = '0;
        for (int n = 0; n < N; n++) begin
            if (cap_start)
                off_we[n] = data_in[n];
            else if (cap_capt)
                off_we[n] = data_in[n] & ~valid_q[wr][n];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c_state    <= C_IDLE;
            cap_cnt    <= '0;
            wr         <= 1'b0;
            full       <= '0;
            overrun    <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
        end else begin
            if (grst && !in_ready)
                overrun <= 1'b1;
            if (cap_start) begin
                c_state     <= C_CAPT;
                cap_cnt     <= TW'(1);
                valid_q[wr] <= data_in;
            end else if (cap_capt) begin
                valid_q[wr] <= valid_q[wr] | data_in;
                cap_cnt     <= cap_cnt + 1'b1;
                if (cap_done) begin
                    c_state <= C_IDLE;
                    wr      <= ~wr;
                end
            end
            // Capture and replay never touch the same bank's full flag on one edge.
            for (int b = 0; b < 2; b++) begin
                if (cap_done && (wr == 1'(b)))
                    full[b] <= 1'b1;
                else if (r_free && (rd == 1'(b)))
                    full[b] <= 1'b0;
            end
        end
    end

    // cap_cnt idles at 0, so it is also the offset for the grst edge itself.
    always_ff @(posedge clk) begin
        for (int n = 0; n < N; n++)
            for (int i = 0; i < P; i++)
                if (off_we[n][i])
                    off_q[wr][n][i] <= cap_cnt;
    end

    // The bank is released when its last replay state is entered, so rd already points
    // at the other bank when deciding whether to continue without a bubble.
    always_comb begin
        r_go    = 1'b0;
        r_free  = 1'b0;
        nxt_net = '0;
        nxt_t   = '0;
        if (r_state == R_IDLE || (net_cnt == LAST_NET && t == LAST_T)) begin
            r_go = full[rd];
        end else begin
            r_go = 1'b1;
            if (t == LAST_T) begin
                nxt_net = net_cnt + 1'b1;
                nxt_t   = '0;
            end else begin
                nxt_net = net_cnt;
                nxt_t   = t + 1'b1;
            end
            r_free = (nxt_net == LAST_NET) && (nxt_t == LAST_T);
        end
        nxt_data = '0;
        for (int i = 0; i < P; i++)
            nxt_data[i] = r_go && valid_q[rd][nxt_net][i] && (off_q[rd][nxt_net][i] == nxt_t);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= R_IDLE;
            net_cnt       <= '0;
            t             <= '0;
            rd            <= 1'b0;
            data_out      <= '0;
            col_grst      <= 1'b0;
            net_id        <= '0;
            replay_active <= 1'b0;
        end else begin
            r_state       <= r_go ? R_PLAY : R_IDLE;
            net_cnt       <= nxt_net;
            t             <= nxt_t;
            data_out      <= nxt_data;
            col_grst      <= r_go && (nxt_t == '0);
            net_id        <= nxt_net;
            replay_active <= r_go;
            if (r_free)
                rd <= ~rd;
        end
    end
endmodule

// File: tb/tb_multi_net_replay_buffer.sv
// Bench for multi_net_replay_buffer: directed scenarios plus random traffic, checked per
// cycle against a window-timeline model (accept edge, capture end, replay start/end).
module tb_multi_net_replay_buffer;
    localparam int P     = 64;
    localparam int N     = 2;
    localparam int GAMMA = 16;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int OW    = 4 + NW + P;

    logic                clk = 1'b0;
    logic                rstb = 1'b0;
    logic                grst = 1'b0;
    logic [N-1:0][P-1:0] data_in = '0;
    logic                in_ready;
    logic                overrun;
    logic [P-1:0]        data_out;
    logic                col_grst;
    logic [NW-1:0]       net_id;
    logic                replay_active;

    always #5 clk = ~clk;

    multi_net_replay_buffer #(.P(P), .N(N), .GAMMA(GAMMA)) dut (
        .clk(clk), .rstb(rstb), .grst(grst), .data_in(data_in),
        .in_ready(in_ready), .overrun(overrun), .data_out(data_out),
        .col_grst(col_grst), .net_id(net_id), .replay_active(replay_active)
    );

    int checks = 0;
    int failures = 0;
    logic [OW-1:0] exp_q[$];

    // Reference model: one entry per accepted window, edges counted from reset release.
    int   ecount;
    int   w_e0[$];
    int   w_c[$];
    int   w_s[$];
    int   w_f[$];
    int   first_off[$];
    logic exp_overrun;

    task automatic model_reset();
        ecount = 0;
        w_e0.delete(); w_c.delete(); w_s.delete(); w_f.delete();
        first_off.delete();
        exp_q.delete();
        exp_overrun = 1'b0;
    endtask

    task automatic model_edge(input logic g, input logic [N-1:0][P-1:0] d);
        int e, nw, cur, k, s, rel, n, tt;
        logic acc, rdy, act, cg;
        logic [NW-1:0] nid;
        logic [P-1:0] dout;
        e = ecount;
        ecount++;
        nw = w_c.size();
        if (nw > 0 && e <= w_c[nw-1]) begin
            cur = nw - 1;
            k = e - w_e0[cur];
            for (int j = 0; j < N * P; j++)
                if (d[j / P][j % P] && first_off[cur * N * P + j] < 0)
                    first_off[cur * N * P + j] = k;
        end
        if (g) begin
            acc = (nw == 0 || w_c[nw-1] < e) && (nw < 2 || w_f[nw-2] < e);
            if (acc) begin
                s = e + GAMMA;
                if (nw > 0 && w_f[nw-1] + 1 > s)
                    s = w_f[nw-1] + 1;
                w_e0.push_back(e);
                w_c.push_back(e + GAMMA - 1);
                w_s.push_back(s);
                w_f.push_back(s + N * GAMMA - 1);
                for (int j = 0; j < N * P; j++)
                    first_off.push_back(d[j / P][j % P] ? 0 : -1);
            end else begin
                exp_overrun = 1'b1;
            end
        end
        dout = '0; act = 1'b0; cg = 1'b0; nid = '0;
        for (int w = 0; w < w_s.size(); w++) begin
            if (e >= w_s[w] && e <= w_f[w]) begin
                rel = e - w_s[w];
                n   = rel / GAMMA;
                tt  = rel % GAMMA;
                act = 1'b1;
                cg  = (tt == 0);
                nid = NW'(n);
                for (int i = 0; i < P; i++)
                    dout[i] = (first_off[w * N * P + n * P + i] == tt);
            end
        end
        nw = w_c.size();
        rdy = (nw == 0 || w_c[nw-1] <= e) && (nw < 2 || w_f[nw-2] <= e);
        exp_q.push_back({exp_overrun, rdy, act, cg, nid, dout});
    endtask

    task automatic step(input logic g, input logic [N-1:0][P-1:0] d);
        grst = g;
        data_in = d;
        @(posedge clk);
        model_edge(g, d);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        grst = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #3 rstb = 1'b1;
        model_reset();
    endtask

    function automatic logic [N-1:0][P-1:0] rand_data(input int den);
        logic [N*P-1:0] v;
        for (int j = 0; j < N * P; j++)
            v[j] = ($urandom_range(0, den - 1) == 0);
        return v;
    endfunction

    task automatic test_reset();
        logic [OW-1:0] got, exp;
        do_reset();
        step(1'b0, '0);
        checks++;
        if (in_ready !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b overrun=%b required 1/0", in_ready, overrun);
        end
        got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", got, exp);
        end
        for (int k = 0; k < 20; k++) begin
            step(k == 0 || k == 4, rand_data(8));
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_activity k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({overrun, replay_active, col_grst, net_id, data_out} !== '0) begin
            failures++;
            $display("FAIL reset_async ov=%b act=%b cg=%b id=%h dout=%h required all 0",
                     overrun, replay_active, col_grst, net_id, data_out);
        end
        #2 rstb = 1'b1;
        model_reset();
        step(1'b0, '0);
        got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || in_ready !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_after_release got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_basic_mapping();
        logic [OW-1:0] got, exp;
        logic [N-1:0][P-1:0] d;
        do_reset();
        for (int k = 0; k < 52; k++) begin
            d = '0;
            if (k == 5) d[0][3] = 1'b1;
            if (k == 9) d[1][3] = 1'b1;
            step(k == 0, d);
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic_model k=%0d got=%h exp=%h", k, got, exp);
            end
            checks++;
            if (data_out[3] !== (k == 21 || k == 41) || col_grst !== (k == 16 || k == 32) ||
                replay_active !== (k >= 16 && k <= 47)) begin
                failures++;
                $display("FAIL basic_timing k=%0d dout3=%b cg=%b act=%b", k, data_out[3], col_grst, replay_active);
            end
            if (k == 21 || k == 41) begin
                checks++;
                if (net_id !== ((k == 41) ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL basic_net_id k=%0d got=%h", k, net_id);
                end
            end
        end
    endtask

    task automatic test_first_spike();
        logic [OW-1:0] got, exp;
        logic [N-1:0][P-1:0] d;
        do_reset();
        for (int k = 0; k < 52; k++) begin
            d = '0;
            if (k == 2 || k == 7) d[0][0] = 1'b1;
            step(k == 0, d);
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL first_model k=%0d got=%h exp=%h", k, got, exp);
            end
            checks++;
            if (data_out[0] !== (k == 18)) begin
                failures++;
                $display("FAIL first_only k=%0d dout0=%b required %b", k, data_out[0], (k == 18));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] got, exp;
        do_reset();
        for (int k = 0; k < 90; k++) begin
            step(k == 0 || k == 16 || k == 32, (k < 48) ? rand_data(16) : '0);
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_model k=%0d got=%h exp=%h", k, got, exp);
            end
            checks++;
            if (in_ready !== (k == 15 || k >= 47) || overrun !== (k >= 32) ||
                col_grst !== (k == 16 || k == 32 || k == 48 || k == 64) ||
                replay_active !== (k >= 16 && k <= 79)) begin
                failures++;
                $display("FAIL b2b_timing k=%0d rdy=%b ov=%b cg=%b act=%b", k, in_ready, overrun, col_grst, replay_active);
            end
            if (k == 48) begin
                checks++;
                if (net_id !== '0) begin
                    failures++;
                    $display("FAIL b2b_net_id k=%0d got=%h required 0", k, net_id);
                end
            end
        end
    endtask

    task automatic test_reset_mid_replay();
        logic [OW-1:0] got, exp;
        do_reset();
        for (int k = 0; k <= 25; k++) begin
            step(k == 0, (k < 16) ? rand_data(8) : '0);
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL midrst_model k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (data_out !== '0 || replay_active !== 1'b0 || col_grst !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async dout=%h act=%b cg=%b required 0", data_out, replay_active, col_grst);
        end
        #2 rstb = 1'b1;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b0, rand_data(8));
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || data_out !== '0 || col_grst !== 1'b0) begin
                failures++;
                $display("FAIL midrst_quiet k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_empty_window();
        logic [OW-1:0] got, exp;
        do_reset();
        for (int k = 0; k < 52; k++) begin
            step(k == 0, '0);
            got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL empty_model k=%0d got=%h exp=%h", k, got, exp);
            end
            checks++;
            if (data_out !== '0 || col_grst !== (k == 16 || k == 32) ||
                replay_active !== (k >= 16 && k <= 47) || in_ready !== (k >= 15)) begin
                failures++;
                $display("FAIL empty_timing k=%0d dout=%h cg=%b act=%b rdy=%b", k, data_out, col_grst, replay_active, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] got, exp;
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            for (int k = 0; k < 400; k++) begin
                step($urandom_range(0, (ph == 0) ? 29 : 4) == 0, rand_data(10));
                got = {overrun, in_ready, replay_active, col_grst, net_id, data_out};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL random_model ph=%0d k=%0d got=%h exp=%h", ph, k, got, exp);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_mapping();
        test_first_spike();
        test_back_to_back();
        test_reset_mid_replay();
        test_empty_window();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
